// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch and execute stages of the bit-serial CPU:
// instruction field widths and the loader phase encoding shown on the LEDs.
package cpu_pkg;

  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 12;

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_HI   = 2'd1,
    S_FULL = 2'd2
  } phase_t;

endpackage

// File: rtl/instr_loader_if.sv
// Valid/ready instruction channel from the loader (master) to the execute stage (slave).
interface instr_loader_if;
  import cpu_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand;

  modport master (output instr_valid, output opcode, output operand, input instr_ready);
  modport slave  (input instr_valid, input opcode, input operand, output instr_ready);

endinterface

// File: rtl/instr_loader_btn_conditioner.sv
// Push-button conditioner: two-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce is built only when BTN_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press
);

  logic sync0;
  logic sync1;
  logic lvl;
  logic lvl_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync0 <= btn_in;
      sync1 <= sync0;
      lvl_d <= lvl;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // The new level is accepted on the edge where the disagreement count reaches DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (sync1 != lvl) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= sync1;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  assign lvl = sync1;
`endif

  assign press = lvl & ~lvl_d;

endmodule

// File: rtl/instr_loader.sv
// Fetch stage: builds a 16-bit instruction from two DIP-switch bytes taken on
// successive button presses. Define BTN_DEBOUNCE_EN to debounce the button.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_in,
  input  logic [7:0]            dip_in,
  instr_loader_if.master        instr,
  output logic [1:0]            phase,
  output logic                  overrun
);

  phase_t               state;
  logic                 press;
  logic                 valid_q;
  logic                 overrun_q;
  logic [OPCODE_W-1:0]  opcode_q;
  logic [OPERAND_W-1:0] operand_q;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn_in),
    .press  (press)
  );

  // The unused encoding 3 falls into the default arm and behaves like S_LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_LO;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      case (state)
        S_HI: begin
          if (press) begin
            operand_q[11:4] <= dip_in;
            valid_q         <= 1'b1;
            state           <= S_FULL;
          end
        end
        S_FULL: begin
          if (instr.instr_ready) begin
            valid_q <= 1'b0;
            state   <= S_LO;
          end
          if (press) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          if (press) begin
            opcode_q       <= dip_in[3:0];
            operand_q[3:0] <= dip_in[7:4];
            state          <= S_HI;
          end else begin
            state <= S_LO;
          end
        end
      endcase
    end
  end

  assign instr.instr_valid = valid_q;
  assign instr.opcode      = opcode_q;
  assign instr.operand     = operand_q;
  assign phase             = state;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (DEBOUNCE_CYCLES=4); expected
// latencies follow BTN_DEBOUNCE_EN when it is defined for the build.
module tb_instr_loader;

`ifdef BTN_DEBOUNCE_EN
  localparam int LAT  = 6;
  localparam int HOLD = 10;
`else
  localparam int LAT  = 2;
  localparam int HOLD = 1;
`endif
  localparam int SETTLE = 12;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic [7:0] dip_in;
  logic       ready;
  logic [1:0] phase;
  logic       overrun;

  int vectors     = 0;
  int miscompares = 0;
  int validCycles = 0;

  instr_loader_if bus ();
  assign bus.instr_ready = ready;

  instr_loader #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_in  (btn_in),
    .dip_in  (dip_in),
    .instr   (bus),
    .phase   (phase),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic b, input logic [7:0] d, input logic r);
    btn_in = b;
    dip_in = d;
    ready  = r;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic doPress(input logic [7:0] d, input int hold);
    applyStimulus(1'b1, d, ready);
    tick(hold);
    btn_in = 1'b0;
    tick(SETTLE);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick(2);
    rst_n = 1'b1;
    checkOutput("reset_valid",   bus.instr_valid, 16'h0);
    checkOutput("reset_opcode",  bus.opcode,      16'h0);
    checkOutput("reset_operand", bus.operand,     16'h0);
    checkOutput("reset_phase",   phase,           16'h0);
    checkOutput("reset_overrun", overrun,         16'h0);

`ifdef BTN_DEBOUNCE_EN
    applyStimulus(1'b1, 8'h77, 1'b0);
    tick(3);
    btn_in = 1'b0;
    tick(SETTLE);
    checkOutput("glitch_phase", phase, 16'h0);
`endif

    // First byte with exact capture-edge timing; release must not capture again.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == HOLD) btn_in = 1'b0;
      if (i == LAT) checkOutput("lat_pre_phase", phase, 16'h0);
      if (i == LAT + 1) checkOutput("lat_post_phase", phase, 16'h1);
    end
    checkOutput("lo_phase_after_release", phase,       16'h1);
    checkOutput("lo_opcode",              bus.opcode,  16'h5);
    checkOutput("lo_operand",             bus.operand, 16'h00A);

    doPress(8'h3C, HOLD);
    checkOutput("full_phase",   phase,           16'h2);
    checkOutput("full_valid",   bus.instr_valid, 16'h1);
    checkOutput("full_operand", bus.operand,     16'h3CA);

    tick(20);
    checkOutput("bp_valid",   bus.instr_valid, 16'h1);
    checkOutput("bp_opcode",  bus.opcode,      16'h5);
    checkOutput("bp_operand", bus.operand,     16'h3CA);

    doPress(8'hFF, HOLD);
    checkOutput("ovr_flag",    overrun,     16'h1);
    checkOutput("ovr_phase",   phase,       16'h2);
    checkOutput("ovr_operand", bus.operand, 16'h3CA);

    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    checkOutput("xfer_valid", bus.instr_valid, 16'h0);
    checkOutput("xfer_phase", phase,           16'h0);

    // Ready held high across a full load: valid must last exactly one cycle.
    ready = 1'b1;
    doPress(8'hA5, HOLD);
    checkOutput("rdy_ignored_phase", phase, 16'h1);
    applyStimulus(1'b1, 8'h3C, 1'b1);
    validCycles = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == HOLD) btn_in = 1'b0;
      if (bus.instr_valid) validCycles++;
    end
    ready = 1'b0;
    checkOutput("one_cycle_valid", 16'(validCycles), 16'h1);
    checkOutput("post_xfer_phase",   phase,       16'h0);
    checkOutput("post_xfer_opcode",  bus.opcode,  16'h5);
    checkOutput("post_xfer_operand", bus.operand, 16'h3CA);
    checkOutput("overrun_sticky",    overrun,     16'h1);

    doPress(8'h12, HOLD);
    checkOutput("shi_phase", phase, 16'h1);
    pulseReset();
    checkOutput("rst_hi_phase",   phase,       16'h0);
    checkOutput("rst_hi_opcode",  bus.opcode,  16'h0);
    checkOutput("rst_hi_operand", bus.operand, 16'h0);
    checkOutput("rst_hi_overrun", overrun,     16'h0);

    doPress(8'h21, 100);
    checkOutput("held_single_phase", phase, 16'h1);
    doPress(8'h43, HOLD);
    checkOutput("reload_valid",   bus.instr_valid, 16'h1);
    checkOutput("reload_opcode",  bus.opcode,      16'h1);
    checkOutput("reload_operand", bus.operand,     16'h432);

    pulseReset();
    checkOutput("rst_full_valid",   bus.instr_valid, 16'h0);
    checkOutput("rst_full_phase",   phase,           16'h0);
    checkOutput("rst_full_operand", bus.operand,     16'h0);

    // Press and ready landing on the same edge in S_FULL.
    doPress(8'h5A, HOLD);
    doPress(8'hC3, HOLD);
    checkOutput("same_pre_operand", bus.operand, 16'hC35);
    applyStimulus(1'b1, 8'h77, 1'b0);
    for (int i = 1; i <= LAT + 1; i++) begin
      tick(1);
      if (i == HOLD) btn_in = 1'b0;
      if (i == LAT) ready = 1'b1;
    end
    checkOutput("same_valid",   bus.instr_valid, 16'h0);
    checkOutput("same_phase",   phase,           16'h0);
    checkOutput("same_overrun", overrun,         16'h1);
    checkOutput("same_opcode",  bus.opcode,      16'hA);
    applyStimulus(1'b0, 8'h77, 1'b0);
    tick(SETTLE);
    checkOutput("same_dropped_phase", phase, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
